// File: rtl/instr_writer_pkg.sv
// Shared definitions for the 8-bit instruction bus writer and reader:
// FSM state encoding, instruction word field positions and pack/unpack helpers.
package instr_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HI   = 2'd1,
        ST_LO   = 2'd2,
        ST_GAP  = 2'd3
    } iw_state_e;

    localparam int OPC_W    = 3;
    localparam int OPC_LSB  = 0;
    localparam int ADDR_W   = 13;
    localparam int ADDR_LSB = 3;
    localparam int WORD_W   = 16;
    localparam int BYTE_W   = 8;
    localparam int GAP_CW   = 3;

    // Word layout: address in [15:3], opcode in [2:0].
    function automatic logic [WORD_W-1:0] pack_word(input logic [ADDR_W-1:0] addr,
                                                    input logic [OPC_W-1:0]  opc);
        logic [WORD_W-1:0] w;
        w = '0;
        w[ADDR_LSB +: ADDR_W] = addr;
        w[OPC_LSB  +: OPC_W]  = opc;
        return w;
    endfunction

    function automatic logic [OPC_W-1:0] unpack_opcode(input logic [WORD_W-1:0] w);
        return w[OPC_LSB +: OPC_W];
    endfunction

    function automatic logic [ADDR_W-1:0] unpack_addr(input logic [WORD_W-1:0] w);
        return w[ADDR_LSB +: ADDR_W];
    endfunction

endpackage

// File: rtl/instr_writer_wr_ptr_cnt.sv
// Write pointer for the instruction bus: loadable, advances by one word
// (two bytes) at a time, and remembers whether it ever rolled over 0x1FFF.
module wr_ptr_cnt
    import instr_writer_pkg::*;
(
    input  logic              clk1,
    input  logic              rst,
    input  logic              ld,
    input  logic [ADDR_W-1:0] ld_val,
    input  logic              adv,
    output logic [ADDR_W-1:0] ptr,
    output logic              wrap
);

    localparam logic [ADDR_W:0] STEP = (ADDR_W+1)'(2);

    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              wrap_q, wrap_d;
    logic [ADDR_W:0]   sum;

    // Next pointer: advancing wins over loading (the owner only loads when idle).
    always_comb begin
        sum    = {1'b0, ptr_q} + STEP;
        ptr_d  = ptr_q;
        wrap_d = wrap_q;
        if (adv) begin
            ptr_d  = sum[ADDR_W-1:0];
            wrap_d = wrap_q | sum[ADDR_W];
        end else if (ld) begin
            ptr_d = ld_val;
        end
    end

    // Pointer and sticky wrap registers.
    always_ff @(posedge clk1) begin
        if (rst) begin
            ptr_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            wrap_q <= wrap_d;
        end
    end

    assign ptr  = ptr_q;
    assign wrap = wrap_q;

endmodule

// File: rtl/instr_writer.sv
// Instruction bus writer: packs {ir_addr, opcode} into a 16-bit word and
// emits it as two consecutive byte strobes (high byte first) at the write
// pointer, followed by GAP idle cycles before the next word.
module instr_writer
    import instr_writer_pkg::*;
#(
    parameter int GAP = 1
) (
    input  logic        clk1,
    input  logic        rst,
    input  logic [2:0]  opcode,
    input  logic [12:0] ir_addr,
    input  logic        load,
    output logic        load_rdy,
    input  logic [12:0] base_addr,
    input  logic        base_ld,
    output logic [7:0]  w_data,
    output logic        w_ena,
    output logic [12:0] w_addr,
    output logic        busy,
    output logic        done,
    output logic        wrap
);

    // Last cycle index inside the GAP state (unused when GAP == 0).
    localparam logic [GAP_CW-1:0] GAP_LAST = (GAP > 0) ? GAP_CW'(GAP - 1) : '0;

    iw_state_e          state_q, state_d;
    logic [GAP_CW-1:0]  gap_cnt_q, gap_cnt_d;
    logic [WORD_W-1:0]  pend_q, pend_d;
    logic               pend_v_q, pend_v_d;
    logic [WORD_W-1:0]  sh_q, sh_d;

    logic [BYTE_W-1:0]  w_data_q, w_data_d;
    logic               w_ena_q, w_ena_d;
    logic [ADDR_W-1:0]  w_addr_q, w_addr_d;
    logic               lo_byte_q, lo_byte_d;
    logic               done_q, done_d;

    logic               load_acc;
    logic               take;
    logic               gap_done;
    logic [ADDR_W-1:0]  ptr;
    logic [ADDR_W-1:0]  ptr_p1;
    logic               ptr_ld;
    logic               ptr_adv;

    wr_ptr_cnt u_ptr (
        .clk1   (clk1),
        .rst    (rst),
        .ld     (ptr_ld),
        .ld_val (base_addr),
        .adv    (ptr_adv),
        .ptr    (ptr),
        .wrap   (wrap)
    );

    // base_ld only lands between words; the pointer steps once per word on leaving LO.
    assign ptr_ld  = (state_q == ST_IDLE) && base_ld;
    assign ptr_adv = (state_q == ST_LO);
    assign ptr_p1  = ptr + ADDR_W'(1);

    // Next-state logic and holding/shift register control.
    // A word leaves the holding register ("take") from IDLE, straight out of LO
    // when there is no gap, or at the last gap cycle, so that exactly GAP
    // strobe-free cycles separate back-to-back words.
    always_comb begin
        load_acc  = load && !pend_v_q;
        gap_done  = (gap_cnt_q == GAP_LAST);
        take      = 1'b0;
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (pend_v_q) begin
                    take    = 1'b1;
                    state_d = ST_HI;
                end
            end
            ST_HI: begin
                state_d = ST_LO;
            end
            ST_LO: begin
                if (GAP > 0) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = '0;
                end else if (pend_v_q) begin
                    take    = 1'b1;
                    state_d = ST_HI;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_done) begin
                    if (pend_v_q) begin
                        take    = 1'b1;
                        state_d = ST_HI;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A refill on the same edge as a take keeps the slot full.
        pend_d   = load_acc ? pack_word(ir_addr, opcode) : pend_q;
        pend_v_d = load_acc ? 1'b1 : (take ? 1'b0 : pend_v_q);
        sh_d     = take ? pend_q : sh_q;
    end

    // Bus outputs for the current state; registered, so they trail the state by a cycle.
    always_comb begin
        w_ena_d   = 1'b0;
        w_data_d  = '0;
        w_addr_d  = w_addr_q;
        lo_byte_d = 1'b0;
        case (state_q)
            ST_HI: begin
                w_ena_d  = 1'b1;
                w_data_d = sh_q[WORD_W-1 -: BYTE_W];
                w_addr_d = ptr;
            end
            ST_LO: begin
                w_ena_d   = 1'b1;
                w_data_d  = sh_q[BYTE_W-1:0];
                w_addr_d  = ptr_p1;
                lo_byte_d = 1'b1;
            end
            default: begin
                w_ena_d = 1'b0;
            end
        endcase
        // done follows the cycle in which the low byte is on the bus.
        done_d = lo_byte_q;
    end

    // FSM, holding register and shift register.
    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gap_cnt_q <= '0;
            pend_q    <= '0;
            pend_v_q  <= 1'b0;
            sh_q      <= '0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            pend_q    <= pend_d;
            pend_v_q  <= pend_v_d;
            sh_q      <= sh_d;
        end
    end

    // Registered bus outputs; reset drops any byte in flight and its done.
    always_ff @(posedge clk1) begin
        if (rst) begin
            w_data_q  <= '0;
            w_ena_q   <= 1'b0;
            w_addr_q  <= '0;
            lo_byte_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            w_data_q  <= w_data_d;
            w_ena_q   <= w_ena_d;
            w_addr_q  <= w_addr_d;
            lo_byte_q <= lo_byte_d;
            done_q    <= done_d;
        end
    end

    assign w_data   = w_data_q;
    assign w_ena    = w_ena_q;
    assign w_addr   = w_addr_q;
    assign done     = done_q;
    assign load_rdy = !pend_v_q;
    assign busy     = (state_q != ST_IDLE) || pend_v_q;

endmodule

// File: tb/tb_instr_writer.sv
// Bench for instr_writer: a random load stream against a word-level model
// (pointer + queue of expected words), checked by an independent bus monitor
// that also rebuilds each instruction from its two bytes. A second instance
// with GAP=0 covers back-to-back streaming.
module tb_instr_writer;

    logic        clk1 = 1'b0;
    logic        rst;
    logic [2:0]  opcode;
    logic [12:0] ir_addr;
    logic        load;
    logic        load_rdy;
    logic [12:0] base_addr;
    logic        base_ld;
    logic [7:0]  w_data;
    logic        w_ena;
    logic [12:0] w_addr;
    logic        busy;
    logic        done;
    logic        wrap;

    logic        load_z;
    logic        base_ld_z;
    logic        load_rdy_z;
    logic [7:0]  w_data_z;
    logic        w_ena_z;
    logic [12:0] w_addr_z;
    logic        busy_z;
    logic        done_z;
    logic        wrap_z;

    always #5 clk1 = ~clk1;

    instr_writer #(.GAP(1)) u_dut (
        .clk1(clk1), .rst(rst), .opcode(opcode), .ir_addr(ir_addr), .load(load),
        .load_rdy(load_rdy), .base_addr(base_addr), .base_ld(base_ld),
        .w_data(w_data), .w_ena(w_ena), .w_addr(w_addr), .busy(busy),
        .done(done), .wrap(wrap)
    );

    instr_writer #(.GAP(0)) u_dut0 (
        .clk1(clk1), .rst(rst), .opcode(opcode), .ir_addr(ir_addr), .load(load_z),
        .load_rdy(load_rdy_z), .base_addr(base_addr), .base_ld(base_ld_z),
        .w_data(w_data_z), .w_ena(w_ena_z), .w_addr(w_addr_z), .busy(busy_z),
        .done(done_z), .wrap(wrap_z)
    );

    typedef struct {
        logic [12:0] addr;
        logic [2:0]  op;
        logic [12:0] ia;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   mptr     = 0;
    bit   mwrap    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s timed out at %0t", name, $time);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        exp_t        cur;
        bit          have_hi;
        bit          lo_prev;
        int          run;
        logic [7:0]  hi_b;
        logic [2:0]  lb_op;
        logic [12:0] lb_ad;
        logic [12:0] last_addr;
        have_hi = 0; lo_prev = 0; run = 0; hi_b = 0; lb_op = 0; lb_ad = 0; last_addr = 0;
        cur = '{addr: 13'h0, op: 3'h0, ia: 13'h0};
        forever begin
            @(negedge clk1);
            if (rst) begin
                have_hi = 0; lo_prev = 0; run = 0; last_addr = 0;
            end else begin
                chk("done_timing", done, lo_prev);
                if (lo_prev) begin
                    chk("loop_opcode", lb_op, cur.op);
                    chk("loop_addr", lb_ad, cur.ia);
                end
                lo_prev = 0;
                if (w_ena) begin
                    run++;
                    last_addr = w_addr;
                    if (!have_hi) begin
                        if (exp_q.size() == 0) begin
                            timeout("unexpected_byte");
                        end else begin
                            cur = exp_q.pop_front();
                            chk("hi_addr", w_addr, cur.addr);
                            chk("hi_data", w_data, cur.ia[12:5]);
                            hi_b    = w_data;
                            have_hi = 1;
                        end
                    end else begin
                        chk("lo_addr", w_addr, 13'(cur.addr + 13'd1));
                        chk("lo_data", w_data, {cur.ia[4:0], cur.op});
                        lb_op   = w_data[2:0];
                        lb_ad   = {hi_b, w_data[7:3]};
                        have_hi = 0;
                        lo_prev = 1;
                    end
                end else begin
                    if (run > 0) chk("ena_run_len", run, 2);
                    run = 0;
                    chk("idle_data", w_data, 8'h00);
                    chk("idle_addr_hold", w_addr, last_addr);
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic do_load(input logic [2:0] op, input logic [12:0] ia);
        int n;
        n = 0;
        while (!load_rdy && n < 200) begin step(); n++; end
        if (n >= 200) timeout("load_rdy_wait");
        load    = 1'b1;
        opcode  = op;
        ir_addr = ia;
        exp_q.push_back('{addr: 13'(mptr), op: op, ia: ia});
        if (mptr >= 13'h1FFE) mwrap = 1;
        mptr = (mptr + 2) % 8192;
        step();
        load = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 500) begin step(); n++; end
        if (n >= 500) timeout("drain");
        repeat (3) step();
    endtask

    task automatic set_base(input logic [12:0] a);
        drain();
        base_addr = a;
        base_ld   = 1'b1;
        step();
        base_ld   = 1'b0;
        mptr      = int'(a);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        logic [7:0]  pat;
        logic [7:0]  zb[4];
        logic [2:0]  op_a, op_b;
        logic [12:0] ia_a, ia_b;
        int          n;
        rst = 1'b1; load = 1'b0; base_ld = 1'b0; load_z = 1'b0; base_ld_z = 1'b0;
        opcode = '0; ir_addr = '0; base_addr = '0;
        repeat (3) step();
        @(negedge clk1);
        chk("rst_w_ena", w_ena, 1'b0);
        chk("rst_w_data", w_data, 8'h00);
        chk("rst_w_addr", w_addr, 13'h0);
        chk("rst_done", done, 1'b0);
        chk("rst_wrap", wrap, 1'b0);
        chk("rst_load_rdy", load_rdy, 1'b1);
        chk("rst_busy", busy, 1'b0);
        step();
        rst = 1'b0;
        step();

        // Directed word with latency and byte values.
        set_base(13'h0100);
        do_load(3'b101, 13'h0ABC);
        @(negedge clk1); chk("lat_cycle0_ena", w_ena, 1'b0);
        @(negedge clk1); chk("lat_cycle1_ena", w_ena, 1'b0); chk("busy_inflight", busy, 1'b1);
        @(negedge clk1); chk("dir_hi_ena", w_ena, 1'b1); chk("dir_hi_data", w_data, 8'h55);
                         chk("dir_hi_addr", w_addr, 13'h0100);
        @(negedge clk1); chk("dir_lo_data", w_data, 8'hE5); chk("dir_lo_addr", w_addr, 13'h0101);
        @(negedge clk1); chk("dir_done", done, 1'b1);
        drain();

        // Back-to-back loads with GAP=1.
        set_base(13'h0100);
        do_load(3'(($urandom)), 13'($urandom));
        chk("b2b_pend_held", load_rdy, 1'b0);
        do_load(3'($urandom), 13'($urandom));
        pat = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk1);
            pat = {pat[6:0], w_ena};
        end
        chk("b2b_ena_pattern", pat, 8'b11011000);
        drain();

        // GAP=0 instance: pending word streams without an idle cycle.
        op_a = 3'($urandom); ia_a = 13'($urandom);
        op_b = 3'($urandom); ia_b = 13'($urandom);
        zb[0] = ia_a[12:5]; zb[1] = {ia_a[4:0], op_a};
        zb[2] = ia_b[12:5]; zb[3] = {ia_b[4:0], op_b};
        opcode = op_a; ir_addr = ia_a; load_z = 1'b1;
        step();
        load_z = 1'b0;
        n = 0;
        while (!load_rdy_z && n < 20) begin step(); n++; end
        if (n >= 20) timeout("gap0_load_rdy");
        opcode = op_b; ir_addr = ia_b; load_z = 1'b1;
        step();
        load_z = 1'b0;
        pat = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk1);
            pat = {pat[6:0], w_ena_z};
            if (i < 4) begin
                chk("gap0_addr", w_addr_z, 13'(i));
                chk("gap0_data", w_data_z, zb[i]);
            end
            if (i == 4) chk("gap0_done", done_z, 1'b1);
        end
        chk("gap0_ena_pattern", pat, 8'b11110000);

        // Pointer wrap at the top of the address space.
        set_base(13'h1FFE);
        do_load(3'($urandom), 13'($urandom));
        drain();
        chk("wrap_set", wrap, mwrap);
        chk("wrap_set_const", wrap, 1'b1);
        do_load(3'($urandom), 13'($urandom));
        drain();
        chk("wrap_sticky", wrap, 1'b1);

        // Random traffic with occasional re-basing.
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 1) == 0) set_base(13'h1FFA + 13'($urandom_range(0, 5)));
                else set_base(13'($urandom));
            end
            do_load(3'($urandom), 13'($urandom));
            repeat ($urandom_range(0, 3)) step();
        end
        drain();
        chk("rand_wrap", wrap, mwrap);

        // Reset in the middle of a word.
        do_load(3'($urandom), 13'($urandom));
        n = 0;
        @(negedge clk1);
        while (!w_ena && n < 10) begin @(negedge clk1); n++; end
        if (n >= 10) timeout("hi_byte_wait");
        #1;
        rst = 1'b1;
        exp_q.delete();
        mptr = 0;
        mwrap = 0;
        @(posedge clk1);
        @(negedge clk1);
        chk("midrst_w_ena", w_ena, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_load_rdy", load_rdy, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_wrap", wrap, 1'b0);
        step();
        rst = 1'b0;
        @(negedge clk1);
        chk("postrst_done", done, 1'b0);
        step();
        do_load(3'($urandom), 13'($urandom));
        drain();
        chk("postrst_wrap", wrap, mwrap);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
